// File: rtl/mcp3_req_queue008_pkg.sv
// Shared sizing and types for the per-source request queue
// feeding the 8-way round-robin arbiter.
package mcp3_req_queue008_pkg;

    localparam int NUM_SRC    = 8;
    localparam int SRC_ID_W   = 3;
    localparam int FIFO_DEPTH = 2;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_EMPTY = 2'd0;
    localparam cnt_t CNT_FULL  = 2'(FIFO_DEPTH);

endpackage

// File: rtl/mcp3_req_queue008_fifo2.sv
// Two-entry command FIFO for one source; exposes occupancy flags
// and the head payload straight from the registers.
module mcp3_req_queue008_fifo2
    import mcp3_req_queue008_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clear_i,
    output logic         ready_o,
    output logic         nempty_o,
    output logic         full_o,
    output logic         pop_err_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] data_q [FIFO_DEPTH];
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    cnt_t         count_q, count_d;
    logic         push, pop;

    assign ready_o   = (count_q != CNT_FULL);
    assign nempty_o  = (count_q != CNT_EMPTY);
    assign full_o    = (count_q == CNT_FULL);
    assign push      = valid_i & ready_o;
    assign pop       = clear_i & nempty_o;
    assign pop_err_o = clear_i & ~nempty_o;
    assign head_o    = data_q[rd_ptr_q];

    always_comb begin
        rd_ptr_d = rd_ptr_q ^ pop;
        wr_ptr_d = wr_ptr_q ^ push;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= CNT_EMPTY;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage is qualified by count, so it needs no reset.
    always_ff @(posedge clock) begin
        if (push) begin
            data_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mcp3_req_queue008.sv
// Upstream request stage for mcp3_arb008: eight 2-entry FIFOs,
// request flags to the arbiter, winner head mux and error flag.
module mcp3_req_queue008
    import mcp3_req_queue008_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            src_valid,
    output logic [NUM_SRC-1:0]            src_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    output logic [NUM_SRC-1:0]            req_bus,
    output logic [NUM_SRC-1:0]            req_bus_2pending,
    input  logic [NUM_SRC-1:0]            req_clear,
    input  logic                          winner_valid,
    input  logic [SRC_ID_W-1:0]           winner,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          err_clear_empty
);

    logic [DATA_WIDTH-1:0] head [NUM_SRC];
    logic [NUM_SRC-1:0]    pop_err;
    logic                  err_q, err_d;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        mcp3_req_queue008_fifo2 #(
            .W(DATA_WIDTH)
        ) u_fifo (
            .clock    (clock),
            .reset    (reset),
            .valid_i  (src_valid[i]),
            .data_i   (src_data[i*DATA_WIDTH +: DATA_WIDTH]),
            .clear_i  (req_clear[i]),
            .ready_o  (src_ready[i]),
            .nempty_o (req_bus[i]),
            .full_o   (req_bus_2pending[i]),
            .pop_err_o(pop_err[i]),
            .head_o   (head[i])
        );
    end

    always_comb begin
        out_valid = winner_valid & req_bus[winner];
        out_data  = '0;
        if (out_valid) begin
            out_data = head[winner];
        end
    end

    assign err_d           = err_q | (|pop_err);
    assign err_clear_empty = err_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

endmodule
